// File: rtl/axil_imem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : axil_imem_rsp
// Purpose  : AXI-lite read responder backed by a word-addressed instruction
//            memory, with fixed or LFSR-random AR-to-R latency.
// Revision : 1.0 - initial release
// ============================================================================
module axil_imem_rsp #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LAT_MODE    = 0,
    parameter int unsigned FIXED_LAT   = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic        ld_en_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i
);

    localparam int unsigned c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN = 32'(DEPTH_WORDS * 4);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_lat_m1;
    logic [7:0]  r_lfsr;
    logic        w_lfsr_fb;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        w_arready;
    logic        w_rvalid;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]     w_rd_off;
    logic            w_rd_err;
    logic [c_AW-1:0] w_rd_idx;
    logic [31:0]     w_ld_off;
    logic            w_ld_ok;
    logic [c_AW-1:0] w_ld_idx;

    // Offsets wrap in 32 bits, so addresses below BASE_ADDR land out of range.
    assign w_rd_off = r_addr - BASE_ADDR;
    assign w_rd_err = (r_addr[1:0] != 2'b00) || (w_rd_off >= c_SPAN);
    assign w_rd_idx = w_rd_off[c_AW+1:2];

    assign w_ld_off = ld_addr_i - BASE_ADDR;
    assign w_ld_ok  = (ld_addr_i[1:0] == 2'b00) && (w_ld_off < c_SPAN);
    assign w_ld_idx = w_ld_off[c_AW+1:2];

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    generate
        if (LAT_MODE == 1) begin : g_lat_rand
            assign w_lat_m1 = {2'b00, r_lfsr[1:0]};
        end else begin : g_lat_fixed
            assign w_lat_m1 = 4'(FIXED_LAT - 1);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (arvalid_i)         w_state_nxt = c_S_WAIT;
            c_S_WAIT: if (r_cnt == 4'd0)     w_state_nxt = c_S_RESP;
            c_S_RESP: if (rready_i)          w_state_nxt = c_S_IDLE;
            default:                         w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_arready = (r_state == c_S_IDLE);
        w_rvalid  = (r_state == c_S_RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_lfsr  <= LFSR_SEED;
            r_addr  <= 32'd0;
            r_rdata <= 32'd0;
            r_rresp <= 2'b00;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            case (r_state)
                c_S_IDLE: begin
                    if (arvalid_i) begin
                        r_addr <= araddr_i;
                        r_cnt  <= w_lat_m1;
                    end
                end
                c_S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= w_rd_err ? 32'd0 : r_mem[w_rd_idx];
                        r_rresp <= w_rd_err ? 2'b10 : 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    // Non-blocking write gives read-before-write against a same-cycle capture.
    always_ff @(posedge clock) begin
        if (ld_en_i && w_ld_ok) begin
            r_mem[w_ld_idx] <= ld_data_i;
        end
    end

    assign arready_o = w_arready;
    assign rvalid_o  = w_rvalid;
    assign rdata_o   = r_rdata;
    assign rresp_o   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_imem_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_imem_rsp
// Purpose  : Directed self-checking bench for axil_imem_rsp (fixed 1, fixed 3
//            and random-latency instances sharing clock, reset and load port).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_imem_rsp;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] araddr = 32'h8000_0000;
    logic [2:0]  arvalid = 3'b000;
    logic [2:0]  rready = 3'b000;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_data = 32'd0;
    logic [2:0]  arready;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];
    logic [1:0]  rresp [3];
    logic [7:0]  m_lfsr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axil_imem_rsp #(.LAT_MODE(0), .FIXED_LAT(1)) u_f1 (
        .clock(clock), .reset(reset), .araddr_i(araddr), .arvalid_i(arvalid[0]),
        .arready_o(arready[0]), .rdata_o(rdata[0]), .rresp_o(rresp[0]),
        .rvalid_o(rvalid[0]), .rready_i(rready[0]), .ld_en_i(ld_en),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data));

    axil_imem_rsp #(.LAT_MODE(0), .FIXED_LAT(3)) u_f3 (
        .clock(clock), .reset(reset), .araddr_i(araddr), .arvalid_i(arvalid[1]),
        .arready_o(arready[1]), .rdata_o(rdata[1]), .rresp_o(rresp[1]),
        .rvalid_o(rvalid[1]), .rready_i(rready[1]), .ld_en_i(ld_en),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data));

    axil_imem_rsp #(.LAT_MODE(1), .LFSR_SEED(8'hA5)) u_rnd (
        .clock(clock), .reset(reset), .araddr_i(araddr), .arvalid_i(arvalid[2]),
        .arready_o(arready[2]), .rdata_o(rdata[2]), .rresp_o(rresp[2]),
        .rvalid_o(rvalid[2]), .rready_i(rready[2]), .ld_en_i(ld_en),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data));

    // Reference LFSR: x^8+x^6+x^5+x^4+1, free-running outside reset
    always @(posedge clock) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [31:0] img(input int k);
        if (k == 0)      return 32'h0000_0413;
        else if (k == 5) return 32'h0000_0001;
        else             return 32'hC0DE_0000 | 32'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // One fetch on instance idx; lat_in < 0 takes the latency from the LFSR model.
    task automatic fetch(input int idx, input logic [31:0] addr, input int hold,
                         input int lat_in, input logic [31:0] d_exp,
                         input logic [1:0] r_exp, input string tag);
        int lat;
        int lat_exp;
        logic [31:0] d0;
        @(negedge clock);
        check({tag, "_arready_idle"}, 32'(arready[idx]), 32'd1);
        araddr = addr; arvalid[idx] = 1'b1; rready[idx] = (hold == 0);
        lat_exp = (lat_in < 0) ? int'(m_lfsr[1:0]) + 1 : lat_in;
        @(negedge clock);
        arvalid[idx] = 1'b0;
        check({tag, "_arready_busy"}, 32'(arready[idx]), 32'd0);
        lat = 0;
        while (!rvalid[idx] && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_rdata"}, rdata[idx], d_exp);
        check({tag, "_rresp"}, 32'(rresp[idx]), 32'(r_exp));
        d0 = rdata[idx];
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, "_hold_rvalid"}, 32'(rvalid[idx]), 32'd1);
            check({tag, "_hold_rdata"}, rdata[idx], d0);
            check({tag, "_hold_arready"}, 32'(arready[idx]), 32'd0);
        end
        rready[idx] = 1'b1;
        @(negedge clock);
        rready[idx] = 1'b0;
        check({tag, "_done_rvalid"}, 32'(rvalid[idx]), 32'd0);
        check({tag, "_done_arready"}, 32'(arready[idx]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_arready", 32'(arready[0]), 32'd1);
        check("rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_rresp", 32'(rresp[0]), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 50; k++) load(32'h8000_0000 + 32'(4 * k), img(k));
        load(32'h8000_3FFC, 32'hDEAD_BEEF);
        load(32'h8000_4000, 32'h0BAD_0BAD);
        load(32'h8000_0002, 32'h0BAD_0BAD);

        // Basic fetch, latency 1
        fetch(0, 32'h8000_0000, 0, 1, 32'h0000_0413, 2'b00, "t1_w0");
        fetch(0, 32'h8000_0004, 0, 1, img(1), 2'b00, "t1_w1");

        // Latency 3 with rready stalled
        fetch(1, 32'h8000_000C, 5, 3, img(3), 2'b00, "t2_stall");
        repeat (2) begin
            @(negedge clock);
            check("t2_single_beat", 32'(rvalid[1]), 32'd0);
        end

        // Decode errors and the last valid word
        fetch(0, 32'h8000_0002, 0, 1, 32'd0, 2'b10, "t3_misaligned");
        fetch(0, 32'h8000_4000, 0, 1, 32'd0, 2'b10, "t3_oor");
        fetch(0, 32'h7FFF_FFFC, 0, 1, 32'd0, 2'b10, "t3_below_base");
        fetch(0, 32'h8000_3FFC, 0, 1, 32'hDEAD_BEEF, 2'b00, "t3_last_word");

        // Random latency sweep
        for (int k = 0; k < 50; k++)
            fetch(2, 32'h8000_0000 + 32'(4 * k), 0, -1, img(k), 2'b00, "t4_rand");

        // Reset while in WAIT
        @(negedge clock);
        araddr = 32'h8000_0008; arvalid[1] = 1'b1;
        @(negedge clock);
        arvalid[1] = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5w_rvalid", 32'(rvalid[1]), 32'd0);
        check("t5w_arready", 32'(arready[1]), 32'd1);
        repeat (5) begin
            @(negedge clock);
            check("t5w_no_stale", 32'(rvalid[1]), 32'd0);
        end
        fetch(1, 32'h8000_0008, 0, 3, img(2), 2'b00, "t5w_next");

        // Reset while in RESP
        @(negedge clock);
        araddr = 32'h8000_0010; arvalid[0] = 1'b1;
        @(negedge clock);
        arvalid[0] = 1'b0;
        @(negedge clock);
        check("t5r_in_resp", 32'(rvalid[0]), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5r_rvalid", 32'(rvalid[0]), 32'd0);
        check("t5r_arready", 32'(arready[0]), 32'd1);
        check("t5r_rdata", rdata[0], 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("t5r_no_stale", 32'(rvalid[0]), 32'd0);
        end
        fetch(0, 32'h8000_0010, 0, 1, img(4), 2'b00, "t5r_next");

        // Backdoor write on the capture cycle is not seen by that read
        @(negedge clock);
        araddr = 32'h8000_0014; arvalid[0] = 1'b1;
        @(negedge clock);
        arvalid[0] = 1'b0;
        ld_en = 1'b1; ld_addr = 32'h8000_0014; ld_data = 32'h0000_0002;
        @(negedge clock);
        ld_en = 1'b0;
        check("t6_rvalid", 32'(rvalid[0]), 32'd1);
        check("t6_old_data", rdata[0], 32'h0000_0001);
        rready[0] = 1'b1;
        @(negedge clock);
        rready[0] = 1'b0;
        fetch(0, 32'h8000_0014, 0, 1, 32'h0000_0002, 2'b00, "t6_new");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_imem_rsp.md
Name: axil_imem_rsp

Overview:
- AXI-lite read-channel responder (slave) that serves instruction fetches from the IFU's `araddr_o`/`arvalid_o`/`arready_i` request port.
- Holds a word-addressed instruction memory and answers each AR handshake with one R beat after a fixed or pseudo-random latency.
- The random mode stresses the fetch handshake.
- A backdoor load port lets the bench preload the program image.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0
- DEPTH_WORDS, 4096, memory depth in 32-bit words (power of 2)
- LAT_MODE, 0, 0 = fixed latency, 1 = LFSR random latency
- FIXED_LAT, 1, AR-to-rvalid latency in cycles when LAT_MODE=0 (1..15)
- LFSR_SEED, 8'hA5, LFSR reset value (nonzero)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- araddr_i  input  32  read address from fetch unit
- arvalid_i  input  1  read address valid
- arready_o  output  1  responder can accept an address
- rdata_o  output  32  read data
- rresp_o  output  2  2'b00 OKAY, 2'b10 SLVERR
- rvalid_o  output  1  read data valid
- rready_i  input  1  fetch unit accepts read data
- ld_en_i  input  1  backdoor word write enable
- ld_addr_i  input  32  backdoor byte address (word index = (addr-BASE_ADDR)>>2)
- ld_data_i  input  32  backdoor write data

Behaviour:
- One clock domain; all state updates on posedge clock.
- Reset is synchronous and active-high.
- Reset values: state=IDLE, arready_o=1, rvalid_o=0, rdata_o=0, rresp_o=0, cnt=0, lfsr=LFSR_SEED.
- Memory array is not cleared by reset.
- Single outstanding transaction. arready_o = (state==IDLE), registered, driven only by state.
- IDLE state:
  - On arvalid_i && arready_o, latch araddr_i and load cnt = L-1.
  - L = FIXED_LAT when LAT_MODE=0.
  - L = lfsr[1:0]+1 (range 1..4) when LAT_MODE=1.
  - Go to WAIT.
- WAIT state:
  - arready_o=0, rvalid_o=0.
  - If cnt!=0, decrement.
  - If cnt==0, capture response and go to RESP. rvalid_o is high exactly L cycles after the AR handshake edge.
- RESP state:
  - rvalid_o=1; rdata_o/rresp_o stay stable until the handshake.
  - On rready_i, go to IDLE. arready_o=1 the following cycle.
  - rvalid_o never drops without rready_i.
- Decode, evaluated at capture:
  - offset = addr - BASE_ADDR (32-bit unsigned, wraps).
  - Error if addr[1:0] != 0 or offset >= DEPTH_WORDS*4. Error response: rresp=2'b10, rdata=0.
  - Otherwise rresp=2'b00, rdata=mem[offset[log2(DEPTH_WORDS)+1:2]].
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every non-reset cycle regardless of state.
  - Its value is sampled on the AR handshake edge.
- Backdoor load:
  - ld_en_i writes mem in any state; out-of-range or misaligned ld_addr_i is ignored.
  - A write to the word being captured in the same cycle is not seen (read-before-write). Writes on earlier cycles are seen.
- arvalid_i asserted outside IDLE is ignored; the master must hold it per AXI until arready_o.
- rready_i outside RESP is ignored.
- Reset mid-transaction (WAIT or RESP): the transaction is dropped, outputs return to reset values next cycle, and no R beat is issued for it.

Test Plan:
1. LAT_MODE=0, FIXED_LAT=1. Preload mem[0]=32'h00000413. arvalid=1, araddr=32'h80000000 at cycle 0 (handshake at cycle 0 edge).
   - rvalid=1 at cycle 1 with rdata=32'h00000413, rresp=0.
   - rready=1 returns arready=1 at cycle 2.
2. FIXED_LAT=3, rready held 0 for 5 cycles after rvalid.
   - rvalid rises 3 cycles after handshake.
   - rdata stays constant, arready stays 0 throughout.
   - Exactly one beat is delivered after rready=1.
3. araddr=32'h80000002 (misaligned) and araddr=32'h80004000 (out of range, DEPTH 4096).
   - Each returns rresp=2'b10, rdata=0.
   - araddr=32'h7FFFFFFC also returns SLVERR.
4. LAT_MODE=1, LFSR_SEED=8'hA5, 50 back-to-back fetches at 0x80000000+4k with rready tied 1.
   - Every latency is in 1..4; data matches the preloaded image.
   - Latency sequence matches a reference LFSR model.
5. Reset asserted in WAIT, and separately in RESP.
   - Next cycle: rvalid=0, arready=1.
   - No stale beat afterwards; the following fetch returns correct data.
6. ld_en to word 5 on the capture cycle of a read of word 5 (old=0x1, new=0x2).
   - Returns 0x1; the next read of word 5 returns 0x2.
